alu_ctrl_seq: RTL and testbench
===============================

# alu_ctrl_seq

Multi-cycle control sequencer that sits in front of `alu` in the RISC datapath. It accepts one 32-bit instruction per handshake and decodes it into the ALU function select (FS[3:0]), register-file addresses and the B-operand mux select. It drives the ALU through an EXEC cycle, captures the returned C/V/Z/N flags, and then either writes the result back or resolves a conditional branch from the captured flags.

## Interface
Parameters:
- `RF_AW`, 5: register-file address width.
- `IMM_W`, 16: immediate width; sign-extended to 32 bits on `imm_out`.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `instr_valid`  in  1: instruction offered.
- `instr_ready`  out  1: sequencer can accept an instruction.
- `instr`  in  32: [31:30] class, [29:26] fs/cond, [25:21] DR, [20:16] SA, [15:11] SB, [15:0] imm.
- `fs`  out  4: ALU function select.
- `sa`, `sb`, `dr`  out  RF_AW each: register addresses.
- `mb`  out  1: 1 selects `imm_out` as the ALU B operand.
- `imm_out`  out  32: sign-extended immediate.
- `alu_c`, `alu_v`, `alu_z`, `alu_n`  in  1 each: ALU flags, valid combinationally during EXEC.
- `rf_we`  out  1: register-file write enable, one-cycle pulse.
- `br_valid`  out  1: branch resolved, one-cycle pulse.
- `br_taken`  out  1: branch outcome, qualified by `br_valid`.
- `br_offset`  out  32: sign-extended imm, qualified by `br_valid`.
- `flags`  out  4: captured {C,V,Z,N}.
- `illegal`  out  1: one-cycle pulse on an undefined fs or cond code.
- `halted`  out  1: level; set after HALT is decoded.

## Operation
Instruction classes (bits [31:30]):
- 00 ALU reg-reg: `mb`=0.
- 01 ALU reg-imm: `mb`=1.
- 10 conditional branch.
- 11: HALT if [29:26]=1111, otherwise NOP.

Legal ALU fs codes: 0000–1000, 1010, 1100, 1110. The codes 1001, 1011, 1101 and 1111 are illegal. An illegal code pulses `illegal`, performs no write, leaves `flags` unchanged and returns to IDLE.

Branch handling:
- EXEC forces `fs`=0101 (A+~B+1, i.e. A−B) and `mb`=0.
- Conditions, evaluated on the captured flags:
  - 0000 EQ: Z.
  - 0001 NE: ~Z.
  - 0010 LT: N^V.
  - 0011 GE: ~(N^V).
  - 0100 LTU: ~C.
  - 0101 GEU: C.
  - 0110 MI: N.
  - 0111 AL: 1.
- Cond codes ≥1000 are illegal: `br_valid` stays 0.

State machine: IDLE, DECODE, EXEC, WB, RESOLVE, HALT.
- IDLE: `instr_ready`=1. On `instr_valid` the instruction is registered → DECODE.
- DECODE: decode registered; illegal → IDLE with `illegal` pulse; NOP → IDLE; HALT → HALT; else → EXEC.
- EXEC: `fs`/`sa`/`sb`/`mb` driven; `flags` ← {alu_c,alu_v,alu_z,alu_n} at clock end; ALU → WB, branch → RESOLVE.
- WB: `rf_we`=1, `dr` valid → IDLE.
- RESOLVE: `br_valid`=1 with `br_taken`/`br_offset` → IDLE.
- HALT: `instr_ready`=0, `halted`=1; exits only on reset.

Output and data rules:
- `fs`, `sa`, `sb`, `dr`, `mb` and `imm_out` hold their decoded values from DECODE through the last state of the instruction. Outside that window they hold 0.
- X on the ALU flags during EXEC of an ALU op is captured as-is. Branch conditions sample only flags captured during a branch EXEC.

Reset values: all outputs 0 except `instr_ready`=1. State IDLE, `flags`=0000.

## Timing
- Handshake at cycle 0.
- ALU op: DECODE c1, EXEC c2, `rf_we` c3, next accept c4. Throughput is one instruction per 4 cycles.
- Branch: `br_valid` c3, next accept c4.
- NOP and illegal: back in IDLE at c2.
- `instr_ready` is registered and is low from c1 until the sequencer re-enters IDLE.
- `instr_valid` while not ready is ignored, not queued.
- Reset asserted mid-instruction: all outputs return to reset values asynchronously. No `rf_we` or `br_valid` pulse follows. First accept occurs on the first clock after deassertion.

## Structure
- Package `risc_pkg`:
  - Class encodings, fs codes (FS_ADD=0010, FS_SUB=0101, …) and cond codes.
  - State enum.
  - Function `is_legal_fs`.
- Sub-module `branch_cond_eval`: combinational; inputs cond[3:0] and flags; outputs `taken` and `illegal_cond`.

## Test plan
- ALU reg-reg: instr=0x08221800 (class 00, fs 0010, DR1, SA2, SB3), with ALU returning Z=1. Expect `fs`=0010 at c2, `rf_we`=1 with `dr`=1 at c3, `flags`=0010 afterwards.
- Reg-imm with negative imm 0xFFF0: expect `mb`=1 and `imm_out`=0xFFFFFFF0 through c1–c3.
- Branch LT, flags N=1 V=0: `br_valid`=1 and `br_taken`=1 at c3. Repeat with N=1 V=1: `br_taken`=0. Repeat with cond 1001: `illegal` pulse and no `br_valid`.
- fs=1011: `illegal` pulse at c1, no `rf_we`, `flags` unchanged, `instr_ready`=1 at c2.
- HALT (0xFC000000): `halted`=1 and `instr_ready` held low for 20 cycles despite `instr_valid`; `rst_n` pulse clears both.
- `rst_n` asserted during EXEC: outputs reset immediately, no `rf_we`; the next instruction is accepted and completes normally.

Source files
------------

// File: rtl/alu_ctrl_seq_pkg.sv
// Shared encodings for the RISC control sequencer: instruction classes,
// ALU function selects, branch conditions and the sequencer state.
package risc_pkg;

  localparam logic [1:0] CLS_ALU_RR = 2'b00;
  localparam logic [1:0] CLS_ALU_RI = 2'b01;
  localparam logic [1:0] CLS_BRANCH = 2'b10;
  localparam logic [1:0] CLS_SYS    = 2'b11;

  localparam logic [3:0] FS_TSF_A   = 4'b0000;
  localparam logic [3:0] FS_INC     = 4'b0001;
  localparam logic [3:0] FS_ADD     = 4'b0010;
  localparam logic [3:0] FS_ADD_INC = 4'b0011;
  localparam logic [3:0] FS_ADD_NB  = 4'b0100;
  localparam logic [3:0] FS_SUB     = 4'b0101;
  localparam logic [3:0] FS_DEC     = 4'b0110;
  localparam logic [3:0] FS_TSF_A2  = 4'b0111;
  localparam logic [3:0] FS_AND     = 4'b1000;
  localparam logic [3:0] FS_OR      = 4'b1010;
  localparam logic [3:0] FS_XOR     = 4'b1100;
  localparam logic [3:0] FS_NOT     = 4'b1110;

  // Class 11 sub-op that stops the sequencer; every other class-11 code is a NOP
  localparam logic [3:0] SYS_HALT   = 4'b1111;

  localparam logic [3:0] COND_EQ    = 4'b0000;
  localparam logic [3:0] COND_NE    = 4'b0001;
  localparam logic [3:0] COND_LT    = 4'b0010;
  localparam logic [3:0] COND_GE    = 4'b0011;
  localparam logic [3:0] COND_LTU   = 4'b0100;
  localparam logic [3:0] COND_GEU   = 4'b0101;
  localparam logic [3:0] COND_MI    = 4'b0110;
  localparam logic [3:0] COND_AL    = 4'b0111;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DECODE  = 3'd1,
    ST_EXEC    = 3'd2,
    ST_WB      = 3'd3,
    ST_RESOLVE = 3'd4,
    ST_HALT    = 3'd5
  } seq_state_e;

  function automatic logic is_legal_fs(input logic [3:0] code);
    logic legal;
    case (code)
      FS_TSF_A, FS_INC, FS_ADD, FS_ADD_INC, FS_ADD_NB, FS_SUB,
      FS_DEC, FS_TSF_A2, FS_AND, FS_OR, FS_XOR, FS_NOT: legal = 1'b1;
      default: legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/alu_ctrl_seq_branch_cond_eval.sv
// Combinational branch-condition evaluator over {C,V,Z,N}; codes with the
// top bit set are undefined and flagged as illegal.
module branch_cond_eval
  import risc_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       taken,
  output logic       illegal_cond
);

  logic c_s;
  logic v_s;
  logic z_s;
  logic n_s;

  assign {c_s, v_s, z_s, n_s} = flags;

  // Condition decode; signed compares use N^V, unsigned compares use the carry
  always_comb begin
    taken        = 1'b0;
    illegal_cond = 1'b0;
    case (cond)
      COND_EQ:  taken = z_s;
      COND_NE:  taken = ~z_s;
      COND_LT:  taken = n_s ^ v_s;
      COND_GE:  taken = ~(n_s ^ v_s);
      COND_LTU: taken = ~c_s;
      COND_GEU: taken = c_s;
      COND_MI:  taken = n_s;
      COND_AL:  taken = 1'b1;
      default:  illegal_cond = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Multi-cycle control sequencer in front of the ALU: decodes one instruction
// per handshake, drives an EXEC cycle, then writes back or resolves a branch.
module alu_ctrl_seq
  import risc_pkg::*;
#(
  parameter int RF_AW = 5,
  parameter int IMM_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [31:0]      instr,
  output logic [3:0]       fs,
  output logic [RF_AW-1:0] sa,
  output logic [RF_AW-1:0] sb,
  output logic [RF_AW-1:0] dr,
  output logic             mb,
  output logic [31:0]      imm_out,
  input  logic             alu_c,
  input  logic             alu_v,
  input  logic             alu_z,
  input  logic             alu_n,
  output logic             rf_we,
  output logic             br_valid,
  output logic             br_taken,
  output logic [31:0]      br_offset,
  output logic [3:0]       flags,
  output logic             illegal,
  output logic             halted
);

  typedef struct packed {
    logic [3:0]       fs;
    logic             mb;
    logic [RF_AW-1:0] sa;
    logic [RF_AW-1:0] sb;
    logic [RF_AW-1:0] dr;
    logic [31:0]      imm;
  } dec_t;

  localparam int   DEC_W    = $bits(dec_t);
  localparam dec_t DEC_ZERO = dec_t'({DEC_W{1'b0}});

  seq_state_e  state_r;
  dec_t        dec_r;
  dec_t        dec_s;
  logic        dec_illegal_s;
  logic [31:0] imm_ext_s;
  logic [3:0]  cond_r;
  logic [3:0]  cond_sel_s;
  logic        is_branch_r;
  logic        is_sys_r;
  logic        is_halt_r;
  logic        taken_s;
  logic        illegal_cond_s;
  logic        instr_ready_r;
  logic        rf_we_r;
  logic        br_valid_r;
  logic        br_taken_r;
  logic [31:0] br_offset_r;
  logic [3:0]  flags_r;
  logic        illegal_r;
  logic        halted_r;

  assign imm_ext_s = {{(32-IMM_W){instr[IMM_W-1]}}, instr[IMM_W-1:0]};

  // The evaluator checks the incoming cond code at accept and the held one at EXEC
  always_comb begin
    if (state_r == ST_IDLE) begin
      cond_sel_s = instr[29:26];
    end else begin
      cond_sel_s = cond_r;
    end
  end

  branch_cond_eval u_cond (
    .cond         (cond_sel_s),
    .flags        ({alu_c, alu_v, alu_z, alu_n}),
    .taken        (taken_s),
    .illegal_cond (illegal_cond_s)
  );

  // Decode of the offered instruction; branches force A-B with a register B operand
  always_comb begin
    dec_s         = DEC_ZERO;
    dec_illegal_s = 1'b0;
    case (instr[31:30])
      CLS_ALU_RR, CLS_ALU_RI: begin
        dec_s.fs      = instr[29:26];
        dec_s.mb      = (instr[31:30] == CLS_ALU_RI);
        dec_s.dr      = instr[21 +: RF_AW];
        dec_s.sa      = instr[16 +: RF_AW];
        dec_s.sb      = instr[11 +: RF_AW];
        dec_s.imm     = imm_ext_s;
        dec_illegal_s = ~is_legal_fs(instr[29:26]);
      end
      CLS_BRANCH: begin
        dec_s.fs      = FS_SUB;
        dec_s.mb      = 1'b0;
        dec_s.sa      = instr[16 +: RF_AW];
        dec_s.sb      = instr[11 +: RF_AW];
        dec_s.imm     = imm_ext_s;
        dec_illegal_s = illegal_cond_s;
      end
      default: begin
        dec_s         = DEC_ZERO;
        dec_illegal_s = 1'b0;
      end
    endcase
  end

  // Sequencer FSM; every output is a register updated here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      dec_r         <= DEC_ZERO;
      cond_r        <= 4'b0000;
      is_branch_r   <= 1'b0;
      is_sys_r      <= 1'b0;
      is_halt_r     <= 1'b0;
      instr_ready_r <= 1'b1;
      rf_we_r       <= 1'b0;
      br_valid_r    <= 1'b0;
      br_taken_r    <= 1'b0;
      br_offset_r   <= 32'h0000_0000;
      flags_r       <= 4'b0000;
      illegal_r     <= 1'b0;
      halted_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (instr_valid && instr_ready_r) begin
            state_r       <= ST_DECODE;
            instr_ready_r <= 1'b0;
            dec_r         <= dec_s;
            illegal_r     <= dec_illegal_s;
            cond_r        <= instr[29:26];
            is_branch_r   <= (instr[31:30] == CLS_BRANCH);
            is_sys_r      <= (instr[31:30] == CLS_SYS);
            is_halt_r     <= (instr[31:30] == CLS_SYS) && (instr[29:26] == SYS_HALT);
          end else begin
            instr_ready_r <= 1'b1;
          end
        end
        ST_DECODE: begin
          illegal_r <= 1'b0;
          if (illegal_r) begin
            state_r       <= ST_IDLE;
            dec_r         <= DEC_ZERO;
            instr_ready_r <= 1'b1;
          end else if (is_halt_r) begin
            state_r  <= ST_HALT;
            halted_r <= 1'b1;
          end else if (is_sys_r) begin
            state_r       <= ST_IDLE;
            instr_ready_r <= 1'b1;
          end else begin
            state_r <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          // Flags are captured raw, including X, so the branch sees exactly what EXEC saw
          flags_r <= {alu_c, alu_v, alu_z, alu_n};
          if (is_branch_r) begin
            state_r     <= ST_RESOLVE;
            br_valid_r  <= 1'b1;
            br_taken_r  <= taken_s;
            br_offset_r <= dec_r.imm;
          end else begin
            state_r <= ST_WB;
            rf_we_r <= 1'b1;
          end
        end
        ST_WB, ST_RESOLVE: begin
          state_r       <= ST_IDLE;
          rf_we_r       <= 1'b0;
          br_valid_r    <= 1'b0;
          br_taken_r    <= 1'b0;
          br_offset_r   <= 32'h0000_0000;
          dec_r         <= DEC_ZERO;
          instr_ready_r <= 1'b1;
        end
        ST_HALT: begin
          state_r       <= ST_HALT;
          instr_ready_r <= 1'b0;
          halted_r      <= 1'b1;
        end
        default: begin
          state_r       <= ST_IDLE;
          dec_r         <= DEC_ZERO;
          instr_ready_r <= 1'b1;
          rf_we_r       <= 1'b0;
          br_valid_r    <= 1'b0;
          br_taken_r    <= 1'b0;
          br_offset_r   <= 32'h0000_0000;
          illegal_r     <= 1'b0;
        end
      endcase
    end
  end

  assign instr_ready = instr_ready_r;
  assign fs          = dec_r.fs;
  assign sa          = dec_r.sa;
  assign sb          = dec_r.sb;
  assign dr          = dec_r.dr;
  assign mb          = dec_r.mb;
  assign imm_out     = dec_r.imm;
  assign rf_we       = rf_we_r;
  assign br_valid    = br_valid_r;
  assign br_taken    = br_taken_r;
  assign br_offset   = br_offset_r;
  assign flags       = flags_r;
  assign illegal     = illegal_r;
  assign halted      = halted_r;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Scoreboard bench for alu_ctrl_seq: each scenario task pushes the expected
// outcome when it issues an instruction and pops it when the DUT responds.
module tb_alu_ctrl_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic [31:0] instr = 32'h0;
  logic        alu_c = 1'b0, alu_v = 1'b0, alu_z = 1'b0, alu_n = 1'b0;
  logic        instr_ready, mb, rf_we, br_valid, br_taken, illegal, halted;
  logic [3:0]  fs, flags;
  logic [4:0]  sa, sb, dr;
  logic [31:0] imm_out, br_offset;

  typedef struct packed {
    logic        is_br;
    logic        is_ill;
    logic [4:0]  dr;
    logic        taken;
    logic [31:0] off;
    logic [3:0]  flags;
    int          cyc;
  } exp_t;

  exp_t       sb_q[$];
  int         n_cmp = 0;
  int         n_err = 0;
  logic [3:0] exp_flags = 4'b0000;

  alu_ctrl_seq #(.RF_AW(5), .IMM_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .fs(fs), .sa(sa), .sb(sb), .dr(dr), .mb(mb), .imm_out(imm_out),
    .alu_c(alu_c), .alu_v(alu_v), .alu_z(alu_z), .alu_n(alu_n),
    .rf_we(rf_we), .br_valid(br_valid), .br_taken(br_taken), .br_offset(br_offset),
    .flags(flags), .illegal(illegal), .halted(halted)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_flags(input logic [3:0] f);
    {alu_c, alu_v, alu_z, alu_n} = f;
  endtask

  function automatic exp_t mk_exp(input logic is_br, input logic is_ill, input logic [4:0] d,
                                  input logic tk, input logic [31:0] off, input logic [3:0] f,
                                  input int cyc);
    exp_t e;
    e = '{is_br: is_br, is_ill: is_ill, dr: d, taken: tk, off: off, flags: f, cyc: cyc};
    return e;
  endfunction

  // Bounded wait for the next rf_we / br_valid / illegal pulse; lat = -1 on timeout
  task automatic wait_event(input int max_cyc, output int lat);
    lat = -1;
    for (int i = 1; i <= max_cyc; i++) begin
      step();
      if (rf_we || br_valid || illegal) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    n_cmp++; if (instr_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b expected 1", instr_ready); end
    n_cmp++; if ({rf_we, br_valid, br_taken, illegal, halted, mb} !== 6'b0) begin n_err++; $display("FAIL reset_pulses: got %b expected 000000", {rf_we, br_valid, br_taken, illegal, halted, mb}); end
    n_cmp++; if ({fs, flags} !== 8'h00) begin n_err++; $display("FAIL reset_fs_flags: got %h expected 00", {fs, flags}); end
    n_cmp++; if ({imm_out, br_offset, sa, sb, dr} !== 79'h0) begin n_err++; $display("FAIL reset_data: got %h expected 0", {imm_out, br_offset, sa, sb, dr}); end
  endtask

  task automatic test_alu_rr();
    int   lat;
    exp_t e;
    step();
    n_cmp++; if (instr_ready !== 1'b1) begin n_err++; $display("FAIL rr_ready_c0: got %b expected 1", instr_ready); end
    instr = 32'h0822_1800; instr_valid = 1'b1;
    sb_q.push_back(mk_exp(1'b0, 1'b0, 5'd1, 1'b0, 32'h0, 4'b0010, 3));
    step();
    instr_valid = 1'b0; set_flags(4'b0010);
    n_cmp++; if (instr_ready !== 1'b0) begin n_err++; $display("FAIL rr_ready_c1: got %b expected 0", instr_ready); end
    step();
    n_cmp++; if (fs !== 4'b0010) begin n_err++; $display("FAIL rr_fs_c2: got %b expected 0010", fs); end
    n_cmp++; if ({sa, sb, mb} !== {5'd2, 5'd3, 1'b0}) begin n_err++; $display("FAIL rr_operands: got %h expected %h", {sa, sb, mb}, {5'd2, 5'd3, 1'b0}); end
    wait_event(3, lat);
    n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL rr_latency: got %0d expected 1", lat); end
    e = sb_q.pop_front();
    n_cmp++; if ({rf_we, br_valid} !== 2'b10) begin n_err++; $display("FAIL rr_kind: got %b expected 10", {rf_we, br_valid}); end
    n_cmp++; if (dr !== e.dr) begin n_err++; $display("FAIL rr_dr: got %0d expected %0d", dr, e.dr); end
    n_cmp++; if (flags !== e.flags) begin n_err++; $display("FAIL rr_flags: got %b expected %b", flags, e.flags); end
    exp_flags = e.flags;
    step();
    n_cmp++; if ({instr_ready, rf_we, fs} !== {1'b1, 1'b0, 4'b0000}) begin n_err++; $display("FAIL rr_c4: got %b expected 100000", {instr_ready, rf_we, fs}); end
    n_cmp++; if (flags !== exp_flags) begin n_err++; $display("FAIL rr_flags_hold: got %b expected %b", flags, exp_flags); end
  endtask

  task automatic test_alu_imm();
    exp_t e;
    step();
    instr = {2'b01, 4'b0010, 5'd4, 5'd5, 16'hFFF0}; instr_valid = 1'b1;
    sb_q.push_back(mk_exp(1'b0, 1'b0, 5'd4, 1'b0, 32'h0, 4'b1001, 3));
    for (int k = 1; k <= 3; k++) begin
      step();
      if (k == 1) begin instr_valid = 1'b0; set_flags(4'b1001); end
      n_cmp++; if ({mb, imm_out} !== {1'b1, 32'hFFFF_FFF0}) begin n_err++; $display("FAIL imm_c%0d: got %b/%h expected 1/fffffff0", k, mb, imm_out); end
    end
    e = sb_q.pop_front();
    n_cmp++; if ({rf_we, dr} !== {1'b1, e.dr}) begin n_err++; $display("FAIL imm_wb: got %b/%0d expected 1/%0d", rf_we, dr, e.dr); end
    n_cmp++; if (flags !== e.flags) begin n_err++; $display("FAIL imm_flags: got %b expected %b", flags, e.flags); end
    exp_flags = e.flags;
    step();
    n_cmp++; if ({mb, imm_out, instr_ready} !== {1'b0, 32'h0, 1'b1}) begin n_err++; $display("FAIL imm_c4: got %b/%h/%b expected 0/0/1", mb, imm_out, instr_ready); end
  endtask

  task automatic test_branch();
    // cond, ALU flags {C,V,Z,N}, imm, expected taken
    logic [3:0]  t_cond[6]  = '{4'b0010, 4'b0010, 4'b0000, 4'b0101, 4'b0111, 4'b0001};
    logic [3:0]  t_flag[6]  = '{4'b0001, 4'b0101, 4'b0010, 4'b0000, 4'b0000, 4'b0010};
    logic [15:0] t_imm[6]   = '{16'h0010, 16'h8004, 16'hFFFE, 16'h0100, 16'h7FFF, 16'h0040};
    logic        t_taken[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    int   lat;
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      step();
      n_cmp++; if (instr_ready !== 1'b1) begin n_err++; $display("FAIL br%0d_ready: got %b expected 1", i, instr_ready); end
      instr = {2'b10, t_cond[i], 5'd0, 5'd6, t_imm[i]}; instr_valid = 1'b1;
      sb_q.push_back(mk_exp(1'b1, 1'b0, 5'd0, t_taken[i], {{16{t_imm[i][15]}}, t_imm[i]}, t_flag[i], 3));
      step();
      instr_valid = 1'b0; set_flags(t_flag[i]);
      step();
      n_cmp++; if ({fs, mb} !== {4'b0101, 1'b0}) begin n_err++; $display("FAIL br%0d_exec: got %b expected 01010", i, {fs, mb}); end
      wait_event(3, lat);
      n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL br%0d_latency: got %0d expected 1", i, lat); end
      e = sb_q.pop_front();
      n_cmp++; if ({br_valid, rf_we} !== 2'b10) begin n_err++; $display("FAIL br%0d_kind: got %b expected 10", i, {br_valid, rf_we}); end
      n_cmp++; if (br_taken !== e.taken) begin n_err++; $display("FAIL br%0d_taken: got %b expected %b", i, br_taken, e.taken); end
      n_cmp++; if (br_offset !== e.off) begin n_err++; $display("FAIL br%0d_offset: got %h expected %h", i, br_offset, e.off); end
      exp_flags = e.flags;
      step();
      n_cmp++; if ({flags, br_valid, instr_ready} !== {exp_flags, 1'b0, 1'b1}) begin n_err++; $display("FAIL br%0d_after: got %b expected %b", i, {flags, br_valid, instr_ready}, {exp_flags, 1'b0, 1'b1}); end
    end
  endtask

  task automatic test_illegal();
    logic [31:0] t_instr[2] = '{{2'b10, 4'b1001, 5'd0, 5'd6, 16'h0020}, {2'b00, 4'b1011, 5'd9, 5'd1, 5'd2, 11'd0}};
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      step();
      instr = t_instr[i]; instr_valid = 1'b1; set_flags(4'b1111);
      sb_q.push_back(mk_exp(1'b0, 1'b1, 5'd0, 1'b0, 32'h0, exp_flags, 1));
      step();
      instr_valid = 1'b0;
      e = sb_q.pop_front();
      n_cmp++; if (illegal !== e.is_ill) begin n_err++; $display("FAIL ill%0d_pulse: got %b expected %b", i, illegal, e.is_ill); end
      step();
      n_cmp++; if ({instr_ready, illegal} !== 2'b10) begin n_err++; $display("FAIL ill%0d_c2: got %b expected 10", i, {instr_ready, illegal}); end
      for (int k = 0; k < 2; k++) begin
        n_cmp++; if ({rf_we, br_valid} !== 2'b00) begin n_err++; $display("FAIL ill%0d_nowrite: got %b expected 00", i, {rf_we, br_valid}); end
        step();
      end
      n_cmp++; if (flags !== e.flags) begin n_err++; $display("FAIL ill%0d_flags: got %b expected %b", i, flags, e.flags); end
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] drs[3] = '{5'd10, 5'd11, 5'd12};
    int   accepted = 0;
    int   seen = 0;
    exp_t e;
    set_flags(4'b0100);
    for (int cyc = 0; cyc < 16; cyc++) begin
      step();
      if (rf_we) begin
        seen++;
        n_cmp++;
        if (sb_q.size() == 0) begin
          n_err++; $display("FAIL b2b_extra: got rf_we dr %0d expected none", dr);
        end else begin
          e = sb_q.pop_front();
          if ({dr, cyc} !== {e.dr, e.cyc}) begin n_err++; $display("FAIL b2b_wb: got dr %0d cyc %0d expected dr %0d cyc %0d", dr, cyc, e.dr, e.cyc); end
        end
      end
      if (accepted < 3) begin
        instr_valid = 1'b1;
        if (instr_ready) begin
          instr = {2'b00, 4'b0010, drs[accepted], 5'd1, 5'd2, 11'd0};
          sb_q.push_back(mk_exp(1'b0, 1'b0, drs[accepted], 1'b0, 32'h0, 4'b0100, cyc + 3));
          accepted++;
        end else begin
          instr = {2'b00, 4'b0010, 5'd31, 5'd1, 5'd2, 11'd0};
        end
      end else begin
        instr_valid = 1'b0;
      end
    end
    exp_flags = 4'b0100;
    n_cmp++; if (seen !== 3) begin n_err++; $display("FAIL b2b_count: got %0d expected 3", seen); end
    n_cmp++; if (sb_q.size() !== 0) begin n_err++; $display("FAIL b2b_pending: got %0d expected 0", sb_q.size()); end
    n_cmp++; if (flags !== exp_flags) begin n_err++; $display("FAIL b2b_flags: got %b expected %b", flags, exp_flags); end
  endtask

  task automatic test_halt();
    step();
    instr = 32'hFC00_0000; instr_valid = 1'b1;
    step();
    instr = {2'b00, 4'b0010, 5'd7, 5'd1, 5'd2, 11'd0};
    n_cmp++; if (instr_ready !== 1'b0) begin n_err++; $display("FAIL halt_c1_ready: got %b expected 0", instr_ready); end
    for (int k = 0; k < 20; k++) begin
      step();
      n_cmp++; if ({halted, instr_ready, rf_we} !== 3'b100) begin n_err++; $display("FAIL halt_hold%0d: got %b expected 100", k, {halted, instr_ready, rf_we}); end
    end
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({halted, instr_ready} !== 2'b01) begin n_err++; $display("FAIL halt_reset: got %b expected 01", {halted, instr_ready}); end
    exp_flags = 4'b0000;
    n_cmp++; if (flags !== exp_flags) begin n_err++; $display("FAIL halt_reset_flags: got %b expected %b", flags, exp_flags); end
    instr_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    n_cmp++; if ({halted, instr_ready} !== 2'b01) begin n_err++; $display("FAIL halt_after: got %b expected 01", {halted, instr_ready}); end
  endtask

  task automatic test_reset_exec();
    exp_t e;
    step();
    instr = {2'b00, 4'b1000, 5'd7, 5'd1, 5'd2, 11'd0}; instr_valid = 1'b1;
    sb_q.push_back(mk_exp(1'b0, 1'b0, 5'd7, 1'b0, 32'h0, 4'b1111, 3));
    step();
    instr_valid = 1'b0; set_flags(4'b1111);
    step();
    n_cmp++; if (fs !== 4'b1000) begin n_err++; $display("FAIL rx_exec_fs: got %b expected 1000", fs); end
    rst_n = 1'b0;
    #1;
    sb_q.delete();
    n_cmp++; if ({fs, mb, dr, instr_ready, rf_we} !== {4'b0, 1'b0, 5'd0, 1'b1, 1'b0}) begin n_err++; $display("FAIL rx_async: got %b expected 00000000001 0", {fs, mb, dr, instr_ready, rf_we}); end
    step();
    rst_n = 1'b1;
    instr = {2'b00, 4'b0010, 5'd3, 5'd4, 5'd5, 11'd0}; instr_valid = 1'b1;
    sb_q.push_back(mk_exp(1'b0, 1'b0, 5'd3, 1'b0, 32'h0, 4'b0001, 3));
    for (int k = 1; k <= 3; k++) begin
      step();
      if (k == 1) begin
        instr_valid = 1'b0; set_flags(4'b0001);
        n_cmp++; if (instr_ready !== 1'b0) begin n_err++; $display("FAIL rx_accept: got %b expected 0", instr_ready); end
      end
      if (k < 3) begin
        n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL rx_no_we%0d: got %b expected 0", k, rf_we); end
      end
    end
    e = sb_q.pop_front();
    n_cmp++; if ({rf_we, dr} !== {1'b1, e.dr}) begin n_err++; $display("FAIL rx_wb: got %b/%0d expected 1/%0d", rf_we, dr, e.dr); end
    n_cmp++; if (flags !== e.flags) begin n_err++; $display("FAIL rx_flags: got %b expected %b", flags, e.flags); end
    step();
    n_cmp++; if (instr_ready !== 1'b1) begin n_err++; $display("FAIL rx_ready: got %b expected 1", instr_ready); end
  endtask

  initial begin
    rst_n = 1'b0;
    step();
    step();
    test_reset();
    rst_n = 1'b1;
    test_alu_rr();
    test_alu_imm();
    test_branch();
    test_illegal();
    test_back_to_back();
    test_halt();
    test_reset_exec();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
